// File: rtl/llc_cmd_issuer.sv
// LLC command issuer: buffers trace records in a small FIFO and issues them to the
// LLC one at a time, waiting for a hit/miss response and keeping saturating statistics.
module llc_cmd_issuer #(
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_cmd,
  input  logic [31:0]      in_addr,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic [4:0]       command,
  output logic [31:0]      address,
  input  logic             rsp_valid,
  input  logic             rsp_hit,
  output logic [CNT_W-1:0] rd_cnt,
  output logic [CNT_W-1:0] wr_cnt,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt,
  output logic [CNT_W-1:0] drop_cnt,
  output logic             timeout_err,
  output logic             busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP} state_t;

  state_t           state_q, state_d;
  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [4:0]       mem_cmd  [DEPTH];
  logic [31:0]      mem_addr [DEPTH];
  logic [4:0]       cmd_q, cmd_d;
  logic [31:0]      addr_q, addr_d;
  logic             cmd_valid_q, cmd_valid_d;
  logic [15:0]      timer_q, timer_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] rd_q, rd_d, wr_q, wr_d, hit_q, hit_d, miss_q, miss_d, drop_q, drop_d;

  logic legal, full, empty, push, drop, pop, handshake;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign legal     = (in_cmd <= 5'd6) || (in_cmd == 5'd8) || (in_cmd == 5'd9);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign push      = in_valid && legal && !full;
  assign drop      = in_valid && !legal;
  assign pop       = (state_q == IDLE) && !empty;
  assign handshake = cmd_valid_q && cmd_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_cmd[wr_ptr_q[AW-1:0]]  <= in_cmd;
      mem_addr[wr_ptr_q[AW-1:0]] <= in_addr;
    end
  end

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    addr_d      = addr_q;
    timer_d     = timer_q;
    timeout_d   = timeout_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    hit_d       = hit_q;
    miss_d      = miss_q;
    drop_d      = drop ? sat_inc(drop_q) : drop_q;
    wr_ptr_d    = wr_ptr_q + (AW+1)'(push);
    rd_ptr_d    = rd_ptr_q + (AW+1)'(pop);
    // cmd_valid is presented one cycle after entering ISSUE and drops on the handshake
    cmd_valid_d = (state_q == ISSUE) && !handshake;

    case (state_q)
      IDLE: begin
        if (!empty) begin
          cmd_d   = mem_cmd[rd_ptr_q[AW-1:0]];
          addr_d  = mem_addr[rd_ptr_q[AW-1:0]];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (handshake) begin
          timer_d = '0;
          state_d = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        if (rsp_valid) begin
          state_d = IDLE;
          case (cmd_q)
            5'd0, 5'd1, 5'd2: begin
              if (cmd_q == 5'd1) wr_d = sat_inc(wr_q);
              else               rd_d = sat_inc(rd_q);
              if (rsp_hit) hit_d  = sat_inc(hit_q);
              else         miss_d = sat_inc(miss_q);
            end
            5'd8: begin
              rd_d   = '0;
              wr_d   = '0;
              hit_d  = '0;
              miss_d = '0;
            end
            default: ;
          endcase
        end else if (timer_q == TO_LAST) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cmd_q       <= '0;
      addr_q      <= '0;
      cmd_valid_q <= 1'b0;
      timer_q     <= '0;
      timeout_q   <= 1'b0;
      rd_q        <= '0;
      wr_q        <= '0;
      hit_q       <= '0;
      miss_q      <= '0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      cmd_valid_q <= cmd_valid_d;
      timer_q     <= timer_d;
      timeout_q   <= timeout_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      hit_q       <= hit_d;
      miss_q      <= miss_d;
      drop_q      <= drop_d;
    end
  end

  assign in_ready    = !full;
  assign cmd_valid   = cmd_valid_q;
  assign command     = cmd_q;
  assign address     = addr_q;
  assign rd_cnt      = rd_q;
  assign wr_cnt      = wr_q;
  assign hit_cnt     = hit_q;
  assign miss_cnt    = miss_q;
  assign drop_cnt    = drop_q;
  assign timeout_err = timeout_q;
  assign busy        = !empty || (state_q != IDLE);

endmodule

// File: tb/tb_llc_cmd_issuer.sv
// Directed + randomized bench for llc_cmd_issuer against a queue-based reference model.
module tb_llc_cmd_issuer;
  localparam int DEPTH   = 4;
  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 4;
  localparam int MAXC    = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready;
  logic [4:0]       in_cmd;
  logic [31:0]      in_addr;
  logic             cmd_valid, cmd_ready;
  logic [4:0]       command;
  logic [31:0]      address;
  logic             rsp_valid, rsp_hit;
  logic [CNT_W-1:0] rd_cnt, wr_cnt, hit_cnt, miss_cnt, drop_cnt;
  logic             timeout_err, busy;

  llc_cmd_issuer #(.DEPTH(DEPTH), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_cmd(in_cmd),
    .in_addr(in_addr), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .command(command),
    .address(address), .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rd_cnt(rd_cnt),
    .wr_cnt(wr_cnt), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .drop_cnt(drop_cnt),
    .timeout_err(timeout_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: records expected at the LLC, in order, plus counters
  logic [4:0]  q_cmd[$];
  logic [31:0] q_addr[$];
  int m_rd, m_wr, m_hit, m_miss, m_drop;
  bit m_to;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_legal(input int c);
    return (c <= 6) || (c == 8) || (c == 9);
  endfunction

  function automatic int sat(input int v);
    return (v >= MAXC) ? MAXC : v + 1;
  endfunction

  task automatic model_reset();
    q_cmd.delete(); q_addr.delete();
    m_rd = 0; m_wr = 0; m_hit = 0; m_miss = 0; m_drop = 0; m_to = 0;
  endtask

  task automatic model_rsp(input logic [4:0] c, input logic h);
    if (c == 0 || c == 1 || c == 2) begin
      if (c == 1) m_wr = sat(m_wr);
      else        m_rd = sat(m_rd);
      if (h) m_hit = sat(m_hit);
      else   m_miss = sat(m_miss);
    end else if (c == 8) begin
      m_rd = 0; m_wr = 0; m_hit = 0; m_miss = 0;
    end
  endtask

  task automatic check_stats(input string tag);
    chk({tag, ".rd"},   32'(rd_cnt),   32'(m_rd));
    chk({tag, ".wr"},   32'(wr_cnt),   32'(m_wr));
    chk({tag, ".hit"},  32'(hit_cnt),  32'(m_hit));
    chk({tag, ".miss"}, 32'(miss_cnt), 32'(m_miss));
    chk({tag, ".drop"}, 32'(drop_cnt), 32'(m_drop));
    chk({tag, ".to"},   32'(timeout_err), 32'(m_to));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".in_ready"},  32'(in_ready), 32'd1);
    chk({tag, ".cmd_valid"}, 32'(cmd_valid), 32'd0);
    chk({tag, ".command"},   32'(command), 32'd0);
    chk({tag, ".address"},   address, 32'd0);
    chk({tag, ".busy"},      32'(busy), 32'd0);
    check_stats(tag);
  endtask

  // one-cycle push starting and ending at a falling edge
  task automatic push(input logic [4:0] c, input logic [31:0] a);
    in_valid = 1'b1; in_cmd = c; in_addr = a;
    if (is_legal(c)) begin q_cmd.push_back(c); q_addr.push_back(a); end
    else m_drop = sat(m_drop);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // wait for the next command; returns 1 if it appeared within budget and matched
  task automatic take_cmd(input string tag, output bit ok);
    int n = 0;
    logic [4:0] ec; logic [31:0] ea;
    ok = 0;
    while (!cmd_valid && n < 50) begin @(negedge clk); n++; end
    chk({tag, ".cmd_valid"}, 32'(cmd_valid), 32'd1);
    if (cmd_valid) begin
      if (q_cmd.size() == 0) begin
        chk({tag, ".unexpected_cmd"}, 32'(command), 32'hFFFF_FFFF);
      end else begin
        ec = q_cmd.pop_front(); ea = q_addr.pop_front();
        chk({tag, ".command"}, 32'(command), 32'(ec));
        chk({tag, ".address"}, address, ea);
        ok = 1;
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        chk({tag, ".cmd_valid_drop"}, 32'(cmd_valid), 32'd0);
      end
    end
  endtask

  // issue + respond after 'delay' idle WAIT_RSP cycles (delay <= TIMEOUT-1)
  task automatic serve(input string tag, input logic h, input int delay);
    bit ok;
    logic [4:0] c;
    c = (q_cmd.size() != 0) ? q_cmd[0] : 5'd31;
    take_cmd(tag, ok);
    if (ok) begin
      repeat (delay) @(negedge clk);
      rsp_valid = 1'b1; rsp_hit = h;
      @(negedge clk);
      rsp_valid = 1'b0; rsp_hit = 1'b0;
      model_rsp(c, h);
      check_stats(tag);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed hang expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int c;
    logic [31:0] a;

    rst = 1'b1; in_valid = 0; in_cmd = 0; in_addr = 0;
    cmd_ready = 0; rsp_valid = 0; rsp_hit = 0;
    model_reset();
    #12;
    check_reset_outputs("reset");
    @(negedge clk); rst = 1'b0;

    // latency: accept at edge N, cmd_valid after edge N+2
    push(5'd0, 32'h1001_9D40);
    chk("lat.n0", 32'(cmd_valid), 32'd0);
    @(negedge clk);
    chk("lat.n1", 32'(cmd_valid), 32'd0);
    @(negedge clk);
    chk("lat.n2", 32'(cmd_valid), 32'd1);
    serve("t1", 1'b0, 0);
    chk("t1.rd_abs", 32'(rd_cnt), 32'd1);
    chk("t1.miss_abs", 32'(miss_cnt), 32'd1);
    chk("t1.busy", 32'(busy), 32'd0);

    // stray response outside WAIT_RSP is ignored
    rsp_valid = 1'b1; rsp_hit = 1'b1;
    @(negedge clk);
    rsp_valid = 1'b0; rsp_hit = 1'b0;
    check_stats("stray");

    // fill: DEPTH in the FIFO plus one held in the command register
    for (int k = 0; k < DEPTH + 1; k++) begin
      chk("fill.in_ready", 32'(in_ready), 32'd1);
      push(5'($urandom_range(0, 2)), $urandom);
    end
    chk("fill.full", 32'(in_ready), 32'd0);
    in_valid = 1'b1; in_cmd = 5'd1; in_addr = 32'hDEAD_BEEF;
    @(negedge clk);
    in_valid = 1'b0;
    chk("fill.still_full", 32'(in_ready), 32'd0);
    for (int k = 0; k < DEPTH + 1; k++) serve("fill.drain", 1'($urandom), $urandom_range(0, 3));
    chk("fill.empty_ready", 32'(in_ready), 32'd1);
    chk("fill.busy", 32'(busy), 32'd0);

    // read, write, clear
    push(5'd0, $urandom); push(5'd1, $urandom); push(5'd8, $urandom);
    serve("clr.rd", 1'b1, 1);
    serve("clr.wr", 1'b0, 2);
    serve("clr.clr", 1'b1, 0);
    chk("clr.rd_zero", 32'(rd_cnt), 32'd0);
    chk("clr.hit_zero", 32'(hit_cnt), 32'd0);

    // drops: 7 and 12 discarded, write issued
    push(5'd7, $urandom); push(5'd12, $urandom); push(5'd1, 32'h0000_1234);
    serve("drop", 1'b1, 3);
    chk("drop.wr_abs", 32'(wr_cnt), 32'd1);
    chk("drop.hit_abs", 32'(hit_cnt), 32'd1);
    chk("drop.busy", 32'(busy), 32'd0);

    // timeout on a read, queued write follows
    push(5'd0, $urandom); push(5'd1, $urandom);
    take_cmd("to", ok);
    for (int i = 1; i <= TIMEOUT; i++) begin
      @(negedge clk);
      chk("to.flag", 32'(timeout_err), 32'(i == TIMEOUT));
    end
    m_to = 1;
    check_stats("to.after");
    serve("to.next", 1'b0, 0);

    // random traffic, including illegal and snoop codes
    for (int i = 0; i < 30; i++) begin
      c = $urandom_range(0, 31);
      if (c == 8) c = 9;
      a = $urandom;
      push(5'(c), a);
      if (is_legal(c)) serve("rand", 1'($urandom), $urandom_range(0, 3));
      else check_stats("rand.drop");
    end

    // saturation
    for (int i = 0; i < MAXC + 3; i++) begin
      push(5'd2, $urandom);
      serve("sat", 1'($urandom), 0);
    end
    chk("sat.rd_max", 32'(rd_cnt), 32'(MAXC));

    // reset during WAIT_RSP with two records queued
    push(5'd0, $urandom); push(5'd1, $urandom); push(5'd2, $urandom);
    take_cmd("rst", ok);
    #2 rst = 1'b1;
    #1 model_reset();
    check_reset_outputs("rst.async");
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("rst.no_issue", 32'(cmd_valid), 32'd0);
    chk("rst.idle", 32'(busy), 32'd0);
    push(5'd1, 32'hCAFE_0040);
    serve("rst.new", 1'b1, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
